// File: rtl/uart_aes_pkg.sv
// Shared constants and controller state encoding for the UART <-> AES block path.
package uart_aes_pkg;

  localparam int unsigned BLOCK_BYTES = 16;
  localparam int unsigned BLOCK_W     = 8 * BLOCK_BYTES;

  typedef enum logic [2:0] {
    StCollect,
    StIssue,
    StWaitRes,
    StTxLoad,
    StTxWaitHi,
    StTxWaitLo
  } ctrl_state_e;

endpackage

// File: rtl/uart_block_ctrl.sv
// Gathers UART RX bytes into a block for the AES core and streams the result back via UART TX.
// Optional inter-byte timeout enabled by defining UART_BLK_TIMEOUT_EN.
module uart_block_ctrl
  import uart_aes_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES  = uart_aes_pkg::BLOCK_BYTES,
  parameter int unsigned TIMEOUT_CLKS = 4340000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               rx_data,
  input  logic                     rx_valid,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  input  logic                     tx_busy,
  output logic [8*BLOCK_BYTES-1:0] blk_out,
  output logic                     blk_valid,
  input  logic                     blk_ready,
  input  logic [8*BLOCK_BYTES-1:0] res_in,
  input  logic                     res_valid,
  output logic                     res_ready,
  output logic                     busy,
  output logic                     rx_drop,
  output logic                     err_tmo
);

  localparam int unsigned BlkW = 8 * BLOCK_BYTES;
  localparam int unsigned IdxW = $clog2(BLOCK_BYTES);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(BLOCK_BYTES - 1);

  ctrl_state_e         state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [BlkW-1:0]     blk_q, blk_d;
  logic [BlkW-1:0]     txb_q, txb_d;
  logic                tmo_hit;

`ifdef UART_BLK_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CLKS);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Only a partially filled block in COLLECT is aged; any received byte restarts the count.
  always_comb begin
    cnt_d   = cnt_q;
    tmo_hit = 1'b0;
    if (state_q != StCollect || idx_q == '0 || rx_valid) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      tmo_hit = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign err_tmo = tmo_hit;
`else
  assign tmo_hit = 1'b0;
  assign err_tmo = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    blk_d     = blk_q;
    txb_d     = txb_q;
    blk_valid = 1'b0;
    res_ready = 1'b0;
    tx_start  = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (rx_valid) begin
          // First byte lands in the most significant byte lane.
          blk_d[8*(BLOCK_BYTES-1-int'(idx_q)) +: 8] = rx_data;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StIssue;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tmo_hit) begin
          idx_d = '0;
          blk_d = '0;
        end
      end
      StIssue: begin
        blk_valid = 1'b1;
        if (blk_ready) state_d = StWaitRes;
      end
      StWaitRes: begin
        res_ready = 1'b1;
        if (res_valid) begin
          txb_d   = res_in;
          state_d = StTxLoad;
        end
      end
      StTxLoad: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = StTxWaitHi;
        end
      end
      StTxWaitHi: begin
        // tx_busy lags tx_start by one cycle; wait for it before looking for the fall.
        if (tx_busy) state_d = StTxWaitLo;
      end
      StTxWaitLo: begin
        if (!tx_busy) begin
          txb_d = txb_q << 8;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StCollect;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = StTxLoad;
          end
        end
      end
      default: state_d = StCollect;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StCollect;
      idx_q   <= '0;
      blk_q   <= '0;
      txb_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      txb_q   <= txb_d;
    end
  end

  assign blk_out = blk_q;
  assign tx_data = txb_q[BlkW-1 -: 8];
  assign busy    = !(state_q == StCollect && idx_q == '0);
  assign rx_drop = rx_valid && (state_q != StCollect);

endmodule

// File: tb/tb_uart_block_ctrl.sv
// Directed self-checking bench for uart_block_ctrl with a behavioural UART TX busy model.
module tb_uart_block_ctrl;

  localparam int BB       = 16;
  localparam int BW       = 8 * BB;
  localparam int BUSY_LEN = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_busy = 1'b0;
  logic [BW-1:0] blk_out;
  logic          blk_valid;
  logic          blk_ready = 1'b0;
  logic [BW-1:0] res_in = '0;
  logic          res_valid = 1'b0;
  logic          res_ready;
  logic          busy;
  logic          rx_drop;
  logic          err_tmo;

  int n_cmp = 0;
  int n_err = 0;

  uart_block_ctrl #(
    .BLOCK_BYTES (BB),
    .TIMEOUT_CLKS(1000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_busy  (tx_busy),
    .blk_out  (blk_out),
    .blk_valid(blk_valid),
    .blk_ready(blk_ready),
    .res_in   (res_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .busy     (busy),
    .rx_drop  (rx_drop),
    .err_tmo  (err_tmo)
  );

  always #5 clk = ~clk;

  // UART TX model: busy rises the cycle after tx_start and stays high BUSY_LEN cycles.
  int         busy_cnt = 0;
  int         tx_cnt = 0;
  int         viol = 0;
  logic       prev_start = 1'b0;
  logic [7:0] tx_log [0:255];

  always @(posedge clk) begin
    if (tx_start && (tx_busy || prev_start)) viol <= viol + 1;
    prev_start <= tx_start;
    if (tx_start) begin
      busy_cnt             <= BUSY_LEN;
      tx_busy              <= 1'b1;
      tx_log[tx_cnt & 255] <= tx_data;
      tx_cnt               <= tx_cnt + 1;
    end else if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      tx_busy  <= (busy_cnt > 1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic send_block(input logic [BW-1:0] blk);
    for (int i = 0; i < BB; i++) send_byte(blk[8*(BB-1-i) +: 8]);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_tx_start"}, tx_start, 0);
    chk({tag, "_blk_valid"}, blk_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_blk_out"}, blk_out, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_rx_drop"}, rx_drop, 0);
    chk({tag, "_err_tmo"}, err_tmo, 0);
  endtask

  // Collect, hold, handshake, return the result and then check the TX byte stream.
  task automatic round(input string tag, input logic [BW-1:0] blk, input logic [BW-1:0] res,
                       input int hold, input bit inject_drop);
    int base;
    int unstable;
    int drops;
    base = tx_cnt;
    unstable = 0;
    send_block(blk);
    chk({tag, "_blk_valid"}, blk_valid, 1);
    chk({tag, "_blk_out"}, blk_out, blk);
    for (int i = 0; i < hold; i++) begin
      tick();
      if (blk_valid !== 1'b1 || blk_out !== blk || res_ready !== 1'b0) unstable++;
    end
    chk({tag, "_hold_stable"}, unstable, 0);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    #1;
    chk({tag, "_blk_valid_drop"}, blk_valid, 0);
    chk({tag, "_res_ready"}, res_ready, 1);
    res_in    = res;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    #1;
    chk({tag, "_res_ready_drop"}, res_ready, 0);
    if (inject_drop) begin
      for (int i = 0; i < 200 && tx_busy !== 1'b1; i++) tick();
      tick();
      tick();
      rx_data  = 8'hA5;
      rx_valid = 1'b1;
      #1;
      drops = int'(rx_drop);
      tick();
      rx_valid = 1'b0;
      #1;
      drops += int'(rx_drop);
      chk({tag, "_rx_drop_once"}, drops, 1);
    end
    for (int i = 0; i < 3000 && (tx_cnt - base) < BB; i++) tick();
    chk({tag, "_tx_count"}, tx_cnt - base, BB);
    for (int i = 0; i < BB; i++)
      chk($sformatf("%s_tx_byte%0d", tag, i), tx_log[(base + i) & 255], res[8*(BB-1-i) +: 8]);
    for (int i = 0; i < 100 && busy !== 1'b0; i++) tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int base;
    int width;
    rst = 1'b1;
    tick();
    tick();
    zero_outputs("reset");
    rst = 1'b0;
    tick();
    zero_outputs("post_reset");

    round("blk1", 128'h00112233445566778899aabbccddeeff,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 50, 1'b1);
    round("blk2", 128'h0123456789abcdeffedcba9876543210,
          128'hdeadbeefcafef00d0badc0de12345678, 0, 1'b0);

`ifdef UART_BLK_TIMEOUT_EN
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i));
    chk("tmo_partial_busy", busy, 1);
    width = 0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (err_tmo === 1'b1) width++;
    end
    chk("tmo_pulse_width", width, 1);
    chk("tmo_idx_zero", busy, 0);
    round("tmo_after", 128'hffeeddccbbaa99887766554433221100,
          128'h00000000111111112222222233333333, 0, 1'b0);
`endif

    // Reset in the middle of the TX stream.
    base = tx_cnt;
    send_block(128'hcafebabe00000000ffffffff12121212);
    blk_ready = 1'b1;
    tick();
    blk_ready = 1'b0;
    res_in    = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    for (int i = 0; i < 2000 && (tx_cnt - base) < 7; i++) tick();
    chk("rst_mid_reached", tx_cnt - base, 7);
    #3;
    rst = 1'b1;
    #1;
    zero_outputs("rst_async");
    tick();
    zero_outputs("rst_held");
    rst = 1'b0;
    for (int i = 0; i < 100 && tx_busy !== 1'b0; i++) tick();
    tick();
    round("post_rst", 128'h00112233445566778899aabbccddeeff,
          128'h69c4e0d86a7b0430d8cdb78070b4c55a, 3, 1'b0);

    chk("tx_protocol_violations", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
